// File: rtl/tt_checker.sv
// Exhaustive 4-input truth-table checker: sweeps abcd 0..15, samples f after SETTLE cycles.
// Optional TT_FIRST_ERR_EN adds first_err/first_err_vld reporting the lowest mismatching vector.
module tt_checker #(
    parameter int SETTLE = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] expected,
    input  logic        f,
    output logic [3:0]  abcd,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] captured,
    output logic [4:0]  err_count
`ifdef TT_FIRST_ERR_EN
    ,
    output logic [3:0]  first_err,
    output logic        first_err_vld
`endif
);

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

    typedef enum logic [1:0] {IDLE, WAIT, SAMPLE, DONE} state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic [15:0] exp_q;
    logic        mismatch;

    assign mismatch = (f != exp_q[abcd]);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            abcd      <= '0;
            cnt       <= '0;
            exp_q     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            captured  <= '0;
            err_count <= '0;
`ifdef TT_FIRST_ERR_EN
            first_err     <= '0;
            first_err_vld <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state     <= WAIT;
                        abcd      <= '0;
                        cnt       <= '0;
                        exp_q     <= expected;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        pass      <= 1'b0;
                        captured  <= '0;
                        err_count <= '0;
`ifdef TT_FIRST_ERR_EN
                        first_err     <= '0;
                        first_err_vld <= 1'b0;
`endif
                    end
                end
                WAIT: begin
                    cnt <= cnt + 4'd1;
                    if (cnt == SETTLE_LAST)
                        state <= SAMPLE;
                end
                SAMPLE: begin
                    captured[abcd] <= f;
                    err_count      <= err_count + 5'(mismatch);
`ifdef TT_FIRST_ERR_EN
                    if (mismatch && !first_err_vld) begin
                        first_err     <= abcd;
                        first_err_vld <= 1'b1;
                    end
`endif
                    if (abcd != 4'd15) begin
                        abcd  <= abcd + 4'd1;
                        cnt   <= '0;
                        state <= WAIT;
                    end else begin
                        // abcd stays at 15; verdict includes this last sample
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (err_count == 5'd0) && !mismatch;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tt_checker.sv
// Directed, table-driven bench for tt_checker: SETTLE=2 instance for sweeps/corners,
// SETTLE=1 instance for the short-settle sweep and restart from DONE.
module tb_tt_checker;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // SETTLE=2 instance; f chosen by mode: 0=AND, 1=zero, 2=XOR
    logic        start1 = 1'b0;
    logic [15:0] expected1 = '0;
    logic [1:0]  mode1 = 2'd0;
    logic        f1;
    logic [3:0]  abcd1;
    logic        busy1, done1, pass1;
    logic [15:0] cap1;
    logic [4:0]  err1;
`ifdef TT_FIRST_ERR_EN
    logic [3:0]  ferr1;
    logic        fvld1;
`endif

    assign f1 = (mode1 == 2'd0) ? (&abcd1) : (mode1 == 2'd1) ? 1'b0 : (^abcd1);

    tt_checker #(.SETTLE(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .expected(expected1), .f(f1),
        .abcd(abcd1), .busy(busy1), .done(done1), .pass(pass1),
        .captured(cap1), .err_count(err1)
`ifdef TT_FIRST_ERR_EN
        , .first_err(ferr1), .first_err_vld(fvld1)
`endif
    );

    // SETTLE=1 instance driven by 4-input XOR
    logic        start2 = 1'b0;
    logic [15:0] expected2 = '0;
    logic        f2;
    logic [3:0]  abcd2;
    logic        busy2, done2, pass2;
    logic [15:0] cap2;
    logic [4:0]  err2;
`ifdef TT_FIRST_ERR_EN
    logic [3:0]  ferr2;
    logic        fvld2;
`endif

    assign f2 = ^abcd2;

    tt_checker #(.SETTLE(1)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .expected(expected2), .f(f2),
        .abcd(abcd2), .busy(busy2), .done(done2), .pass(pass2),
        .captured(cap2), .err_count(err2)
`ifdef TT_FIRST_ERR_EN
        , .first_err(ferr2), .first_err_vld(fvld2)
`endif
    );

    typedef struct {
        logic [1:0]  mode;
        logic [15:0] expected;
        logic [15:0] cap;
        logic [4:0]  err;
        logic        pass;
        logic [3:0]  first;
        logic        fvld;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, req);
        end
    endtask

    // Inputs change at negedge; outputs sampled at negedge, half a period after the active edge.
    task automatic start_sweep1(input logic [15:0] e);
        @(negedge clk);
        expected1 = e;
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
    endtask

    // lat counts the accept cycle as cycle 1; done should be seen in cycle 16*(SETTLE+1)+1.
    task automatic wait_done1(output int lat);
        lat = 1;
        while (!done1 && lat < 300) begin
            if (busy1 && done1) check("busy_done_overlap", 1, 0);
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic wait_abcd1(input logic [3:0] v);
        int k = 0;
        while (abcd1 != v && k < 300) begin
            @(negedge clk);
            k++;
        end
        check("wait_abcd_timeout", int'(k >= 300), 0);
    endtask

    initial begin
        int lat;

        vecs[0] = '{2'd0, 16'h8000, 16'h8000, 5'd0,  1'b1, 4'd0,  1'b0};
        vecs[1] = '{2'd0, 16'h8001, 16'h8000, 5'd1,  1'b0, 4'd0,  1'b1};
        vecs[2] = '{2'd1, 16'hFFFF, 16'h0000, 5'd16, 1'b0, 4'd0,  1'b1};
        vecs[3] = '{2'd2, 16'h6996, 16'h6996, 5'd0,  1'b1, 4'd0,  1'b0};
        vecs[4] = '{2'd0, 16'h0000, 16'h8000, 5'd1,  1'b0, 4'd15, 1'b1};
        vecs[5] = '{2'd2, 16'h0000, 16'h6996, 5'd8,  1'b0, 4'd1,  1'b1};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_abcd", abcd1, 0);
        check("rst_busy", busy1, 0);
        check("rst_done", done1, 0);
        check("rst_pass", pass1, 0);
        check("rst_cap", cap1, 0);
        check("rst_err", err1, 0);
        check("rst_busy2", busy2, 0);
        rst_n = 1'b1;

        // Table-driven full sweeps
        for (int i = 0; i < 6; i++) begin
            mode1 = vecs[i].mode;
            start_sweep1(vecs[i].expected);
            check($sformatf("v%0d_busy", i), busy1, 1);
            check($sformatf("v%0d_done_low", i), done1, 0);
            wait_done1(lat);
            check($sformatf("v%0d_lat", i), lat, 49);
            check($sformatf("v%0d_cap", i), cap1, vecs[i].cap);
            check($sformatf("v%0d_err", i), err1, vecs[i].err);
            check($sformatf("v%0d_pass", i), pass1, vecs[i].pass);
            check($sformatf("v%0d_busy_end", i), busy1, 0);
            check($sformatf("v%0d_abcd_end", i), abcd1, 15);
`ifdef TT_FIRST_ERR_EN
            check($sformatf("v%0d_fvld", i), fvld1, vecs[i].fvld);
            if (vecs[i].fvld) check($sformatf("v%0d_ferr", i), ferr1, vecs[i].first);
`endif
            repeat (2) @(negedge clk);
            check($sformatf("v%0d_done_hold", i), done1, 1);
        end

        // start and expected changes mid-sweep are ignored
        mode1 = 2'd0;
        start_sweep1(16'h8000);
        wait_abcd1(4'd7);
        expected1 = 16'h0000;
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        check("midstart_busy", busy1, 1);
        check("midstart_abcd", abcd1 >= 4'd7, 1);
        wait_done1(lat);
        lat = lat + 0;
        check("midstart_cap", cap1, 16'h8000);
        check("midstart_err", err1, 0);
        check("midstart_pass", pass1, 1);

        // Reset mid-sweep aborts; reset wins over start on the same edge
        start_sweep1(16'h8000);
        wait_abcd1(4'd9);
        rst_n = 1'b0;
        start1 = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        start1 = 1'b0;
        check("midrst_abcd", abcd1, 0);
        check("midrst_busy", busy1, 0);
        check("midrst_done", done1, 0);
        check("midrst_pass", pass1, 0);
        check("midrst_cap", cap1, 0);
        check("midrst_err", err1, 0);
        repeat (5) @(negedge clk);
        check("midrst_idle_busy", busy1, 0);
        check("midrst_idle_done", done1, 0);
        start_sweep1(16'h8000);
        wait_done1(lat);
        check("postrst_lat", lat, 49);
        check("postrst_cap", cap1, 16'h8000);
        check("postrst_pass", pass1, 1);

        // SETTLE=1 sweep, then restart from DONE
        @(negedge clk);
        expected2 = 16'h6996;
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        lat = 1;
        while (!done2 && lat < 300) begin
            @(negedge clk);
            lat++;
        end
        check("s1_lat", lat, 33);
        check("s1_cap", cap2, 16'h6996);
        check("s1_err", err2, 0);
        check("s1_pass", pass2, 1);
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        check("s1_restart_done", done2, 0);
        check("s1_restart_busy", busy2, 1);
        check("s1_restart_cap", cap2, 0);
        check("s1_restart_abcd", abcd2, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
